rfphoenix_ptg_cache: RTL and testbench
======================================

// Module: rfphoenix_ptg_cache
// PURPOSE
// Parametrised page-table-group cache sitting between the MMU hash-table walker and memory.
// Holds DEPTH recently fetched PTGs, each with PTE_PER_PTG hash PTEs.
// Performs a pipelined 2-cycle lookup: PTG tag compare, then PTE match.
// Supports line fill, invalidate-by-address and invalidate-all.
// Successor to the fixed 8-entry PTGCE array: depth and group size are configurable, and the PTE match is done in-cache.
// PARAMETERS
// DEPTH        8   number of cached PTGs (power of 2, >=2)
// PTE_PER_PTG  8   HPTEs per group (power of 2)
// PORTS
// clk          in   1             clock
// rst          in   1             synchronous reset, active-high
// lu_v_i       in   1             lookup request valid
// lu_rdy_o     out  1             lookup accepted this cycle
// lu_adr_i     in   Address       PTG base (data) address
// lu_vpn_i     in   16            virtual page number low
// lu_vpnhi_i   in   32            virtual page number high
// lu_asid_i    in   10            address-space id
// res_v_o      out  1             result valid (2 cycles after accept)
// res_tag_hit_o out 1             PTG present in cache
// res_pte_hit_o out 1             matching PTE found in PTG
// res_idx_o    out  $clog2(PTE_PER_PTG)   index of matching PTE
// res_pte_o    out  HPTE(128)     matching PTE, zero if none
// fill_v_i     in   1             write PTG into cache
// fill_adr_i   in   Address       PTG base address for fill
// fill_ptg_i   in   PTE_PER_PTG*128   PTG data
// inv_i        in   1             invalidate entry whose tag == inv_adr_i
// inv_adr_i    in   Address       address for inv_i
// inv_all_i    in   1             invalidate all entries
// BEHAVIOUR
// - Reset: all entry valid bits 0; replacement ptr 0; stage valids 0.
//   res_v_o, res_tag_hit_o, res_pte_hit_o = 0; res_idx_o = 0; res_pte_o = 0.
// - Write priority per cycle: rst > inv_all_i > inv_i > fill_v_i.
//   A cycle never applies both an invalidate and a fill; a lower-priority request the same cycle is dropped.
// - lu_rdy_o = !(fill_v_i | inv_i | inv_all_i) (combinational). A lookup is accepted when lu_v_i & lu_rdy_o.
// - Stage 1 (accept cycle):
//   - Compare lu_adr_i against all valid tags; lowest index wins on multiple hits.
//   - Register tag_hit, the hit PTG contents and the lookup key.
//   - The registered PTG copy isolates stage 2 from later fills/invalidates.
// - Stage 2 (next cycle):
//   - PTE i matches when v & vpn==lu_vpn & vpnhi==lu_vpnhi & (g | asid==lu_asid).
//   - The lowest matching i wins. Outputs are registered.
//   - res_v_o is high exactly 1 cycle, at accept+2.
//   - If tag miss: res_pte_hit_o=0, res_pte_o=0, res_idx_o=0.
// - Throughput: 1 lookup/cycle, no bubbles; results are returned in order.
// - Fill:
//   - If fill_adr_i already tagged valid: overwrite that entry; ptr unchanged.
//   - Else victim = lowest invalid entry; ptr unchanged.
//   - Else victim = ptr, and ptr = (ptr+1) mod DEPTH (wraps).
// - inv_i: clears the valid bit of a matching tag; no-op on miss.
// - inv_all_i: clears every valid bit; ptr reset to 0.
// - Lookups in flight during a write complete using the old data captured in stage 1.
// - rst mid-lookup: in-flight results are discarded; no res_v_o is produced.
// STRUCTURE
// - rfPhoenixMmupkg gains PTGC_DEP-style defaults plus a parametrised PTG typedef (HPTE array of PTE_PER_PTG).
// - rfPhoenixMmupkg gains the HPTE match function (vpn/vpnhi/asid/g compare).
// - Sub-module rfphoenix_pte_prio_match: combinational priority scan returning hit/idx/pte.
//   It is instantiated once in stage 2.
// - Tag array and valid bits are in flops; PTG data may map to distributed RAM with 1 write and DEPTH compare reads.
// TESTING
// - Reset, then lookup 0x1000 -> res_v_o at +2; tag_hit=0, pte_hit=0, pte=0.
// - Fill 0x1000 with PTE[3]{vpn=0x12,asid=5,v=1}; lookup vpn 0x12 asid 5 -> tag_hit=1, pte_hit=1, idx=3.
// - Same PTG: lookup asid 6 -> pte_hit=0. Then set g=1 on PTE[3], refill, repeat -> pte_hit=1, idx=3.
// - Fill DEPTH+2 distinct addresses:
//   - The first DEPTH fill invalid slots 0..DEPTH-1.
//   - The next two evict entries 0 and 1; lookups of the first two addresses miss.
// - Back-to-back lookups on 3 cycles, with fill_v_i on cycle 2:
//   - lu_rdy_o=0 on cycle 2.
//   - 2 results are returned in order; the in-flight result shows the pre-fill data.
// - inv_i 0x1000 then lookup -> tag miss.
// - inv_all_i then refill -> slot 0 reused.
// - rst asserted with 2 lookups in flight -> no res_v_o.

Source files
------------

// File: rtl/rfphoenix_ptg_cache_pkg.sv
// Shared types and helpers for the page-table-group cache.
package rfphoenix_ptg_cache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned HPTE_W     = 128;
  localparam int unsigned PTGC_DEPTH = 8;
  localparam int unsigned PTGC_PTES  = 8;

  typedef logic [ADDR_W-1:0] address_t;

  // Hash PTE layout, MSB first.
  typedef struct packed {
    logic        v;
    logic        g;
    logic [9:0]  asid;
    logic [31:0] vpnhi;
    logic [15:0] vpn;
    logic [67:0] rsvd;
  } hpte_t;

  // A PTE matches when valid, both VPN halves agree, and it is global or the ASID agrees.
  function automatic logic hpte_match(input hpte_t p, input logic [15:0] vpn,
                                      input logic [31:0] vpnhi, input logic [9:0] asid);
    return p.v && (p.vpn == vpn) && (p.vpnhi == vpnhi) && (p.g || (p.asid == asid));
  endfunction

endpackage

// File: rtl/rfphoenix_ptg_cache_pte_prio_match.sv
// Combinational priority scan of one PTG: lowest matching PTE wins.
module rfphoenix_pte_prio_match
  import rfphoenix_ptg_cache_pkg::*;
#(
  parameter int unsigned PTE_PER_PTG = PTGC_PTES,
  localparam int unsigned IDX_W = (PTE_PER_PTG > 1) ? $clog2(PTE_PER_PTG) : 1
) (
  input  hpte_t [PTE_PER_PTG-1:0] ptg,
  input  logic [15:0]             vpn,
  input  logic [31:0]             vpnhi,
  input  logic [9:0]              asid,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output hpte_t                   pte
);

  // Scan upward; the first match locks out later ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pte = '0;
    for (int unsigned i = 0; i < PTE_PER_PTG; i++) begin
      if (!hit && hpte_match(ptg[i], vpn, vpnhi, asid)) begin
        hit = 1'b1;
        idx = i[IDX_W-1:0];
        pte = ptg[i];
      end
    end
  end

endmodule

// File: rtl/rfphoenix_ptg_cache.sv
// Page-table-group cache: DEPTH PTGs, 2-cycle pipelined lookup (tag compare, then PTE match),
// fill with round-robin replacement, invalidate-by-address and invalidate-all.
module rfphoenix_ptg_cache
  import rfphoenix_ptg_cache_pkg::*;
#(
  parameter int unsigned DEPTH       = PTGC_DEPTH,
  parameter int unsigned PTE_PER_PTG = PTGC_PTES,
  localparam int unsigned IDX_W = (PTE_PER_PTG > 1) ? $clog2(PTE_PER_PTG) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lu_v_i,
  output logic                          lu_rdy_o,
  input  address_t                      lu_adr_i,
  input  logic [15:0]                   lu_vpn_i,
  input  logic [31:0]                   lu_vpnhi_i,
  input  logic [9:0]                    lu_asid_i,
  output logic                          res_v_o,
  output logic                          res_tag_hit_o,
  output logic                          res_pte_hit_o,
  output logic [IDX_W-1:0]              res_idx_o,
  output hpte_t                         res_pte_o,
  input  logic                          fill_v_i,
  input  address_t                      fill_adr_i,
  input  logic [PTE_PER_PTG*HPTE_W-1:0] fill_ptg_i,
  input  logic                          inv_i,
  input  address_t                      inv_adr_i,
  input  logic                          inv_all_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef hpte_t [PTE_PER_PTG-1:0] ptg_t;

  logic [DEPTH-1:0] valid_q;
  address_t         tag_q  [DEPTH];
  ptg_t             data_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  logic             lu_acc;
  logic             lu_hit,   fill_hit,   inv_hit,   free_found;
  logic [PTR_W-1:0] lu_slot,  fill_slot,  inv_slot,  free_slot;
  logic [PTR_W-1:0] victim;
  logic             fill_we;

  logic             s1_v_q, s1_hit_q;
  ptg_t             s1_ptg_q;
  logic [15:0]      s1_vpn_q;
  logic [31:0]      s1_vpnhi_q;
  logic [9:0]       s1_asid_q;

  logic             m_hit;
  logic [IDX_W-1:0] m_idx;
  hpte_t            m_pte;

  assign lu_rdy_o = !(fill_v_i || inv_i || inv_all_i);
  assign lu_acc   = lu_v_i && lu_rdy_o;
  assign fill_we  = fill_v_i && !inv_i && !inv_all_i && !rst;

  // Tag searches for lookup, fill and invalidate, plus first free slot; lowest index wins.
  always_comb begin
    lu_hit     = 1'b0;  lu_slot   = '0;
    fill_hit   = 1'b0;  fill_slot = '0;
    inv_hit    = 1'b0;  inv_slot  = '0;
    free_found = 1'b0;  free_slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!lu_hit && valid_q[i] && (tag_q[i] == lu_adr_i)) begin
        lu_hit  = 1'b1;
        lu_slot = i[PTR_W-1:0];
      end
      if (!fill_hit && valid_q[i] && (tag_q[i] == fill_adr_i)) begin
        fill_hit  = 1'b1;
        fill_slot = i[PTR_W-1:0];
      end
      if (!inv_hit && valid_q[i] && (tag_q[i] == inv_adr_i)) begin
        inv_hit  = 1'b1;
        inv_slot = i[PTR_W-1:0];
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_slot  = i[PTR_W-1:0];
      end
    end
  end

  // Victim choice: existing copy, else lowest free slot, else round-robin pointer.
  always_comb begin
    victim = ptr_q;
    if (fill_hit)        victim = fill_slot;
    else if (free_found) victim = free_slot;
  end

  // Valid bits and replacement pointer; one write per cycle in priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (inv_i) begin
      if (inv_hit) valid_q[inv_slot] <= 1'b0;
    end else if (fill_v_i) begin
      valid_q[victim] <= 1'b1;
      if (!fill_hit && !free_found) ptr_q <= ptr_q + PTR_W'(1);
    end
  end

  // Tag and PTG storage, kept reset-free so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[victim]  <= fill_adr_i;
      data_q[victim] <= fill_ptg_i;
    end
  end

  // Stage 1 valid.
  always_ff @(posedge clk) begin
    if (rst) s1_v_q <= 1'b0;
    else     s1_v_q <= lu_acc;
  end

  // Stage 1 payload: private PTG copy so later writes cannot disturb stage 2.
  always_ff @(posedge clk) begin
    if (lu_acc) begin
      s1_hit_q   <= lu_hit;
      s1_ptg_q   <= data_q[lu_slot];
      s1_vpn_q   <= lu_vpn_i;
      s1_vpnhi_q <= lu_vpnhi_i;
      s1_asid_q  <= lu_asid_i;
    end
  end

  rfphoenix_pte_prio_match #(
    .PTE_PER_PTG(PTE_PER_PTG)
  ) u_match (
    .ptg  (s1_ptg_q),
    .vpn  (s1_vpn_q),
    .vpnhi(s1_vpnhi_q),
    .asid (s1_asid_q),
    .hit  (m_hit),
    .idx  (m_idx),
    .pte  (m_pte)
  );

  // Stage 2 registered result; everything but res_v_o is zero on a tag miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_v_o       <= 1'b0;
      res_tag_hit_o <= 1'b0;
      res_pte_hit_o <= 1'b0;
      res_idx_o     <= '0;
      res_pte_o     <= '0;
    end else begin
      res_v_o       <= s1_v_q;
      res_tag_hit_o <= s1_v_q && s1_hit_q;
      res_pte_hit_o <= s1_v_q && s1_hit_q && m_hit;
      res_idx_o     <= (s1_v_q && s1_hit_q && m_hit) ? m_idx : '0;
      res_pte_o     <= (s1_v_q && s1_hit_q && m_hit) ? m_pte : '0;
    end
  end

endmodule

// File: tb/tb_rfphoenix_ptg_cache.sv
// Directed bench for rfphoenix_ptg_cache (DEPTH=8, PTE_PER_PTG=8).
module tb_rfphoenix_ptg_cache;
  import rfphoenix_ptg_cache_pkg::*;

  localparam int unsigned D = 8;
  localparam int unsigned P = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          lu_v_i, lu_rdy_o;
  address_t      lu_adr_i;
  logic [15:0]   lu_vpn_i;
  logic [31:0]   lu_vpnhi_i;
  logic [9:0]    lu_asid_i;
  logic          res_v_o, res_tag_hit_o, res_pte_hit_o;
  logic [2:0]    res_idx_o;
  hpte_t         res_pte_o;
  logic          fill_v_i;
  address_t      fill_adr_i;
  logic [P*128-1:0] fill_ptg_i;
  logic          inv_i;
  address_t      inv_adr_i;
  logic          inv_all_i;

  int compared = 0;
  int mismatched = 0;

  rfphoenix_ptg_cache #(.DEPTH(D), .PTE_PER_PTG(P)) dut (
    .clk(clk), .rst(rst),
    .lu_v_i(lu_v_i), .lu_rdy_o(lu_rdy_o), .lu_adr_i(lu_adr_i),
    .lu_vpn_i(lu_vpn_i), .lu_vpnhi_i(lu_vpnhi_i), .lu_asid_i(lu_asid_i),
    .res_v_o(res_v_o), .res_tag_hit_o(res_tag_hit_o), .res_pte_hit_o(res_pte_hit_o),
    .res_idx_o(res_idx_o), .res_pte_o(res_pte_o),
    .fill_v_i(fill_v_i), .fill_adr_i(fill_adr_i), .fill_ptg_i(fill_ptg_i),
    .inv_i(inv_i), .inv_adr_i(inv_adr_i), .inv_all_i(inv_all_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  function automatic hpte_t mk(input logic g, input logic [9:0] asid,
                               input logic [31:0] vpnhi, input logic [15:0] vpn);
    hpte_t p;
    p = '0;
    p.v = 1'b1; p.g = g; p.asid = asid; p.vpnhi = vpnhi; p.vpn = vpn;
    p.rsvd = {52'h0, vpn ^ 16'hA5C3};
    return p;
  endfunction

  task automatic fill(input string nm, input address_t adr, input hpte_t [P-1:0] ptg);
    fill_v_i = 1'b1; fill_adr_i = adr; fill_ptg_i = ptg;
    #1;
    chk({nm, ".rdy"}, 128'(lu_rdy_o), 128'(0));
    tick();
    fill_v_i = 1'b0;
  endtask

  task automatic lookup(input string nm, input address_t adr, input logic [15:0] vpn,
                        input logic [31:0] vpnhi, input logic [9:0] asid,
                        input logic etag, input logic epte, input logic [2:0] eidx,
                        input hpte_t ep);
    lu_v_i = 1'b1; lu_adr_i = adr; lu_vpn_i = vpn; lu_vpnhi_i = vpnhi; lu_asid_i = asid;
    tick();
    lu_v_i = 1'b0;
    chk({nm, ".v+1"}, 128'(res_v_o), 128'(0));
    tick();
    chk({nm, ".v"},    128'(res_v_o),       128'(1));
    chk({nm, ".tag"},  128'(res_tag_hit_o), 128'(etag));
    chk({nm, ".pte"},  128'(res_pte_hit_o), 128'(epte));
    chk({nm, ".idx"},  128'(res_idx_o),     128'(eidx));
    chk({nm, ".data"}, 128'(res_pte_o),     128'(ep));
    tick();
    chk({nm, ".v+3"}, 128'(res_v_o), 128'(0));
  endtask

  function automatic address_t adr_a(input int unsigned i);
    return 32'h2000 + 32'(i) * 32'h100;
  endfunction

  function automatic address_t adr_q(input int unsigned i);
    return 32'h8000 + 32'(i) * 32'h100;
  endfunction

  hpte_t [P-1:0] pa, pg, pold, pnew;
  hpte_t [P-1:0] pn [10];
  hpte_t [P-1:0] pq [9];
  hpte_t z;

  initial begin
    z = '0;
    rst = 1'b1; lu_v_i = 1'b0; lu_adr_i = '0; lu_vpn_i = '0; lu_vpnhi_i = '0; lu_asid_i = '0;
    fill_v_i = 1'b0; fill_adr_i = '0; fill_ptg_i = '0;
    inv_i = 1'b0; inv_adr_i = '0; inv_all_i = 1'b0;
    tick(); tick();
    chk("rst.v",    128'(res_v_o),       128'(0));
    chk("rst.tag",  128'(res_tag_hit_o), 128'(0));
    chk("rst.pte",  128'(res_pte_hit_o), 128'(0));
    chk("rst.idx",  128'(res_idx_o),     128'(0));
    chk("rst.data", 128'(res_pte_o),     128'(0));
    chk("rst.rdy",  128'(lu_rdy_o),      128'(1));
    rst = 1'b0;
    tick();

    // Empty cache misses.
    lookup("empty", 32'h1000, 16'h12, 32'h0, 10'd5, 1'b0, 1'b0, 3'd0, z);

    // PTG with two candidates for the same key; lowest index (3) must win.
    pa = '0;
    pa[3] = mk(1'b0, 10'd5, 32'h0, 16'h12);
    pa[5] = mk(1'b0, 10'd7, 32'h0, 16'h12);
    pa[6] = mk(1'b0, 10'd5, 32'h0, 16'h12);
    fill("fillA", 32'h1000, pa);
    lookup("hitA",   32'h1000, 16'h12, 32'h0, 10'd5, 1'b1, 1'b1, 3'd3, pa[3]);
    lookup("asid6",  32'h1000, 16'h12, 32'h0, 10'd6, 1'b1, 1'b0, 3'd0, z);
    lookup("vpnhi",  32'h1000, 16'h12, 32'h1, 10'd5, 1'b1, 1'b0, 3'd0, z);

    // Global bit overrides ASID.
    pg = pa;
    pg[3].g = 1'b1;
    fill("fillG", 32'h1000, pg);
    lookup("global", 32'h1000, 16'h12, 32'h0, 10'd6, 1'b1, 1'b1, 3'd3, pg[3]);

    // Capacity: inv_all, then DEPTH+2 fills; the last two evict slots 0 and 1.
    inv_all_i = 1'b1; tick(); inv_all_i = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      pn[i] = '0;
      pn[i][0] = mk(1'b0, 10'd0, 32'h0, 16'(32'h100 + i));
      fill("fillN", adr_a(i), pn[i]);
    end
    lookup("evict0", adr_a(0), 16'h100, 32'h0, 10'd0, 1'b0, 1'b0, 3'd0, z);
    lookup("evict1", adr_a(1), 16'h101, 32'h0, 10'd0, 1'b0, 1'b0, 3'd0, z);
    lookup("keep2",  adr_a(2), 16'h102, 32'h0, 10'd0, 1'b1, 1'b1, 3'd0, pn[2][0]);
    lookup("keep8",  adr_a(8), 16'h108, 32'h0, 10'd0, 1'b1, 1'b1, 3'd0, pn[8][0]);
    lookup("keep9",  adr_a(9), 16'h109, 32'h0, 10'd0, 1'b1, 1'b1, 3'd0, pn[9][0]);
    // Pointer now at 2: next new fill evicts address 2.
    fill("fill10", adr_a(10), pn[0]);
    lookup("evict2", adr_a(2), 16'h102, 32'h0, 10'd0, 1'b0, 1'b0, 3'd0, z);
    lookup("keep3",  adr_a(3), 16'h103, 32'h0, 10'd0, 1'b1, 1'b1, 3'd0, pn[3][0]);

    // Back-to-back lookups with a fill on the middle cycle.
    pold = pn[9];
    pnew = '0;
    pnew[4] = mk(1'b0, 10'd0, 32'h0, 16'h109);
    lu_adr_i = adr_a(9); lu_vpn_i = 16'h109; lu_vpnhi_i = '0; lu_asid_i = '0;
    lu_v_i = 1'b1;
    tick();
    fill_v_i = 1'b1; fill_adr_i = adr_a(9); fill_ptg_i = pnew;
    #1;
    chk("b2b.rdy", 128'(lu_rdy_o), 128'(0));
    tick();
    fill_v_i = 1'b0;
    chk("b2b.r1v",   128'(res_v_o),   128'(1));
    chk("b2b.r1idx", 128'(res_idx_o), 128'(0));
    chk("b2b.r1pte", 128'(res_pte_o), 128'(pold[0]));
    tick();
    lu_v_i = 1'b0;
    chk("b2b.gap", 128'(res_v_o), 128'(0));
    tick();
    chk("b2b.r2v",   128'(res_v_o),   128'(1));
    chk("b2b.r2idx", 128'(res_idx_o), 128'(4));
    chk("b2b.r2pte", 128'(res_pte_o), 128'(pnew[4]));
    tick();
    chk("b2b.end", 128'(res_v_o), 128'(0));

    // Pointer at 3 (overwrite left it alone): 0x1000 evicts address 3.
    fill("fill1000", 32'h1000, pg);
    lookup("evict3", adr_a(3), 16'h103, 32'h0, 10'd0, 1'b0, 1'b0, 3'd0, z);
    lookup("hit1000", 32'h1000, 16'h12, 32'h0, 10'd6, 1'b1, 1'b1, 3'd3, pg[3]);
    // inv_i and fill in the same cycle: invalidate wins, fill is dropped.
    inv_i = 1'b1; inv_adr_i = 32'h1000;
    fill("invfill", 32'h1000, pg);
    inv_i = 1'b0;
    lookup("inv1000", 32'h1000, 16'h12, 32'h0, 10'd6, 1'b0, 1'b0, 3'd0, z);
    // Invalidate of an absent address changes nothing.
    inv_i = 1'b1; inv_adr_i = 32'hDEAD0000; tick(); inv_i = 1'b0;
    lookup("invmiss", adr_a(9), 16'h109, 32'h0, 10'd0, 1'b1, 1'b1, 3'd4, pnew[4]);

    // inv_all resets the pointer: after 9 fills, the first one (slot 0) is evicted.
    inv_all_i = 1'b1; tick(); inv_all_i = 1'b0;
    lookup("invall", adr_a(9), 16'h109, 32'h0, 10'd0, 1'b0, 1'b0, 3'd0, z);
    for (int unsigned i = 0; i < 9; i++) begin
      pq[i] = '0;
      pq[i][1] = mk(1'b0, 10'd3, 32'h55, 16'(32'h200 + i));
      fill("fillQ", adr_q(i), pq[i]);
    end
    lookup("slot0", adr_q(0), 16'h200, 32'h55, 10'd3, 1'b0, 1'b0, 3'd0, z);
    lookup("q1",    adr_q(1), 16'h201, 32'h55, 10'd3, 1'b1, 1'b1, 3'd1, pq[1][1]);
    lookup("q8",    adr_q(8), 16'h208, 32'h55, 10'd3, 1'b1, 1'b1, 3'd1, pq[8][1]);

    // Reset with two lookups in flight: no result may appear.
    lu_adr_i = adr_q(1); lu_vpn_i = 16'h201; lu_vpnhi_i = 32'h55; lu_asid_i = 10'd3;
    lu_v_i = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; lu_v_i = 1'b0;
    chk("rstfl.v0", 128'(res_v_o), 128'(0));
    tick();
    chk("rstfl.v1", 128'(res_v_o), 128'(0));
    tick();
    chk("rstfl.v2", 128'(res_v_o), 128'(0));
    lookup("rstfl.miss", adr_q(1), 16'h201, 32'h55, 10'd3, 1'b0, 1'b0, 3'd0, z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
